// File: rtl/bcd_countdown_if.sv
// Front-panel command / display bus for the BCD countdown controller.
//   master : drives start, stop, clear, load, load_val (and lap when enabled)
//   slave  : drives bcd_out, tick, running, done (and lap_val when enabled)
// Optional feature macro: BCD_LAP_HOLD_EN adds lap (command) and lap_val (result).
interface bcd_countdown_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  tick;
  logic                  running;
  logic                  done;
`ifdef BCD_LAP_HOLD_EN
  logic                  lap;
  logic [4*DIGITS-1:0]   lap_val;

  modport master (output start, stop, clear, load, load_val, lap,
                  input  bcd_out, tick, running, done, lap_val);
  modport slave  (input  start, stop, clear, load, load_val, lap,
                  output bcd_out, tick, running, done, lap_val);
`else
  modport master (output start, stop, clear, load, load_val,
                  input  bcd_out, tick, running, done);
  modport slave  (input  start, stop, clear, load, load_val,
                  output bcd_out, tick, running, done);
`endif
endinterface

// File: rtl/bcd_countdown_ctrl.sv
// BCD countdown timer controller.
// Sequences a DIGITS-wide cascade of BCD decade counters: prescales the clock into
// count ticks, borrows digit to digit on each decrement and runs an
// IDLE/RUN/PAUSE/DONE state machine driven by one-cycle front-panel pulses.
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - bcd_countdown_if.slave: start/stop/clear/load/load_val in,
//          bcd_out/tick/running/done out
// Optional feature macro: BCD_LAP_HOLD_EN adds a lap capture register
// (bus.lap in, bus.lap_val out) that snapshots the value in RUN or PAUSE.
module bcd_countdown_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100000
) (
  input  logic           clk,
  input  logic           rst,
  bcd_countdown_if.slave bus
);

  localparam int VAL_W = 4 * DIGITS;
  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [VAL_W-1:0] value;
  logic             tick_r;
  logic             running_r;
  logic             done_r;
  logic [VAL_W-1:0] value_dec;

  // One BCD unit down; a digit at 0 wraps to 9 and passes the borrow upward.
  function automatic logic [VAL_W-1:0] bcd_dec(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Non-decimal preset digits are saturated to 9 so the cascade stays valid BCD.
  function automatic logic [VAL_W-1:0] bcd_clamp(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  assign value_dec = bcd_dec(value);

  // Commands resolve as one priority chain: clear > load > start > stop > counting.
  // A command that does not apply in the current state falls through, so e.g. a
  // load during RUN does not stall the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre       <= '0;
      value     <= '0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      if (bus.clear) begin
        state     <= IDLE;
        pre       <= '0;
        value     <= '0;
        running_r <= 1'b0;
        done_r    <= 1'b0;
      end else if (bus.load && state != RUN) begin
        value <= bcd_clamp(bus.load_val);
        if (state == DONE) begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
      end else if (bus.start && (state == IDLE || state == PAUSE)) begin
        // A zero value can never be counted down, so go straight to DONE.
        if (value == '0) begin
          state     <= DONE;
          running_r <= 1'b0;
          done_r    <= 1'b1;
        end else begin
          state     <= RUN;
          running_r <= 1'b1;
          // Resuming from PAUSE keeps the partial prescaler count.
          if (state == IDLE) pre <= '0;
        end
      end else if (bus.stop && state == RUN) begin
        state     <= PAUSE;
        running_r <= 1'b0;
      end else if (state == RUN) begin
        if (pre == PRE_LAST) begin
          pre    <= '0;
          tick_r <= 1'b1;
          value  <= value_dec;
          if (value_dec == '0) begin
            state     <= DONE;
            running_r <= 1'b0;
            done_r    <= 1'b1;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  assign bus.bcd_out = value;
  assign bus.tick    = tick_r;
  assign bus.running = running_r;
  assign bus.done    = done_r;

`ifdef BCD_LAP_HOLD_EN
  logic [VAL_W-1:0] lap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q <= '0;
    end else if (bus.clear) begin
      lap_q <= '0;
    end else if (bus.lap && (state == RUN || state == PAUSE)) begin
      lap_q <= value;
    end
  end

  assign bus.lap_val = lap_q;
`endif

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed testbench for bcd_countdown_ctrl with DIGITS=2, PRESCALE=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same
// point, i.e. they show the result of the edge just taken.
module tb_bcd_countdown_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   tick_seen;

  logic [7:0] exp2 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                            8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  always #5 clk = ~clk;

  bcd_countdown_if #(.DIGITS(2)) b ();

  bcd_countdown_ctrl #(.DIGITS(2), .PRESCALE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b.start = 0; b.stop = 0; b.clear = 0; b.load = 0; b.load_val = '0;
`ifdef BCD_LAP_HOLD_EN
    b.lap = 0;
`endif
    // 1: reset held two cycles with start asserted
    rst = 1; b.start = 1;
    cyc(); cyc();
    rst = 0; b.start = 0;
    chk("rst_bcd", b.bcd_out, 8'h00);
    chk("rst_tick", b.tick, 0);
    chk("rst_running", b.running, 0);
    chk("rst_done", b.done, 0);
    cyc();
    chk("rst_start_ignored_done", b.done, 0);
    chk("rst_start_ignored_run", b.running, 0);

    // 2: count 12 down to 00
    b.load_val = 8'h12; b.load = 1; cyc(); b.load = 0;
    chk("load12", b.bcd_out, 8'h12);
    b.start = 1; cyc(); b.start = 0;
    chk("run_after_start", b.running, 1);
    chk("tick_after_start", b.tick, 0);
    for (int n = 0; n < 12; n++) begin
      tick_seen = 0;
      repeat (3) begin cyc(); if (b.tick) tick_seen++; end
      chk("no_early_tick", tick_seen, 0);
      cyc();
      chk("tick_pulse", b.tick, 1);
      chk("count_val", b.bcd_out, exp2[n]);
      if (n == 11) begin
        chk("done_at_zero", b.done, 1);
        chk("running_at_zero", b.running, 0);
      end else begin
        chk("running_mid", b.running, 1);
      end
    end
    cyc();
    chk("tick_single", b.tick, 0);
    b.start = 1; cyc(); b.start = 0;
    cyc();
    chk("done_sticky", b.done, 1);
    chk("done_bcd", b.bcd_out, 8'h00);
    chk("done_no_tick", b.tick, 0);

    // 3: pause and resume with prescaler retained
    b.load_val = 8'h05; b.load = 1; cyc(); b.load = 0;
    chk("load_from_done_val", b.bcd_out, 8'h05);
    chk("load_from_done_done", b.done, 0);
    b.start = 1; cyc(); b.start = 0;
    repeat (3) cyc();
    cyc();
    chk("p_tick", b.tick, 1);
    chk("p_val04", b.bcd_out, 8'h04);
    cyc(); cyc();
    b.stop = 1; cyc(); b.stop = 0;
    chk("paused_running", b.running, 0);
    tick_seen = 0;
    repeat (10) begin cyc(); if (b.tick) tick_seen++; end
    chk("paused_no_tick", tick_seen, 0);
    chk("paused_frozen", b.bcd_out, 8'h04);
    b.start = 1; cyc(); b.start = 0;
    chk("resume_running", b.running, 1);
    chk("resume_tick0", b.tick, 0);
    cyc();
    chk("resume_tick1", b.tick, 0);
    cyc();
    chk("resume_tick2", b.tick, 1);
    chk("resume_val03", b.bcd_out, 8'h03);

    // 4: load sanitising and load ignored while running
    b.load_val = 8'h77; b.load = 1; cyc(); b.load = 0;
    chk("load_in_run", b.bcd_out, 8'h03);
    chk("load_in_run_running", b.running, 1);
    b.stop = 1; cyc(); b.stop = 0;
    b.load_val = 8'hA3; b.load = 1; cyc(); b.load = 0;
    chk("clamp_A3", b.bcd_out, 8'h93);
    b.load_val = 8'hFF; b.load = 1; cyc(); b.load = 0;
    chk("clamp_FF", b.bcd_out, 8'h99);
    chk("load_in_pause_running", b.running, 0);
    b.clear = 1; cyc(); b.clear = 0;
    chk("clear_bcd", b.bcd_out, 8'h00);
    chk("clear_done", b.done, 0);

    // 5: start with zero value in IDLE
    b.start = 1; cyc(); b.start = 0;
    chk("zero_start_done", b.done, 1);
    chk("zero_start_running", b.running, 0);
    chk("zero_start_tick", b.tick, 0);
    tick_seen = 0;
    repeat (6) begin cyc(); if (b.tick) tick_seen++; end
    chk("zero_start_no_tick", tick_seen, 0);

    // 6: lap capture (optional) and clear+start in RUN
    b.load_val = 8'h08; b.load = 1; cyc(); b.load = 0;
    chk("load08", b.bcd_out, 8'h08);
    b.start = 1; cyc(); b.start = 0;
    repeat (4) cyc();
    chk("c_tick07", b.tick, 1);
    chk("c_val07", b.bcd_out, 8'h07);
`ifdef BCD_LAP_HOLD_EN
    b.lap = 1; cyc(); b.lap = 0;
    chk("lap_capture", b.lap_val, 8'h07);
`else
    cyc();
`endif
    cyc(); cyc(); cyc();
    chk("c_tick06", b.tick, 1);
    chk("c_val06", b.bcd_out, 8'h06);
`ifdef BCD_LAP_HOLD_EN
    chk("lap_held", b.lap_val, 8'h07);
`endif
    b.clear = 1; b.start = 1; cyc(); b.clear = 0; b.start = 0;
    chk("clr_start_running", b.running, 0);
    chk("clr_start_bcd", b.bcd_out, 8'h00);
    chk("clr_start_done", b.done, 0);
`ifdef BCD_LAP_HOLD_EN
    chk("lap_cleared", b.lap_val, 8'h00);
`endif
    repeat (5) cyc();
    chk("clr_stays_idle", b.running, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
